instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: pops decoded instructions and issues unified-buffer read/write beats.
// Define SEQ_PERF_CNT_EN to add the saturating busy-cycle counter port perf_cycles_o.

package tpu_package;
  // Address fields are 16 bits wide; the sequencer uses the low ADDR_W bits (ADDR_W <= 16).
  typedef struct packed {
    logic [2:0]  MAC_op;
    logic [7:0]  U_dim;
    logic [7:0]  V_dim;
    logic [7:0]  ITER_dim;
    logic [15:0] unified_buffer_addr_start_rd;
    logic [15:0] unified_buffer_addr_start_wr;
  } decode_registers_t;
endpackage

module instruction_sequencer
  import tpu_package::*;
#(
  parameter int ADDR_W = 12,
  parameter int WR_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iq_empty_i,
  input  decode_registers_t instr_i,
  input  logic              stall_i,
  output logic              instruction_read_o,
  output logic              ub_rd_en_o,
  output logic [ADDR_W-1:0] ub_rd_addr_o,
  output logic              ub_wr_en_o,
  output logic [ADDR_W-1:0] ub_wr_addr_o,
  output logic [2:0]        mac_op_o,
  output logic [7:0]        u_dim_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              op_err_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles_o
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [15:0]       beat_r, n_beats_r, last_idx_s, n_prod_s;
  logic [ADDR_W-1:0] start_rd_r, start_wr_r;
  logic [WR_LAT-1:0] pipe_v_r;
  logic [15:0]       pipe_idx_r [WR_LAT];

  logic              op_ok_s, no_beats_s, advance_s;
  logic              rd_issue_s, last_rd_s, wr_issue_s, last_wr_s;
  logic              read_s, rd_en_s, wr_en_s, busy_s, done_s, op_err_s;
  logic [ADDR_W-1:0] rd_addr_s, wr_addr_s;
  logic [2:0]        mac_op_s;
  logic [7:0]        u_dim_s;
  logic              addr_unused_s;

  assign addr_unused_s = ^{instr_i.unified_buffer_addr_start_rd, instr_i.unified_buffer_addr_start_wr};
  assign op_ok_s       = (instr_i.MAC_op == 3'b010);
  assign no_beats_s    = (instr_i.V_dim == 8'd0) || (instr_i.ITER_dim == 8'd0);
  assign n_prod_s      = 16'(instr_i.V_dim) * 16'(instr_i.ITER_dim);
  assign last_idx_s    = n_beats_r - 16'd1;
  // Stall freezes both read issue and the write delay line.
  assign advance_s     = ((state_r == RUN) || (state_r == DRAIN)) && !stall_i;
  assign rd_issue_s    = (state_r == RUN) && !stall_i;
  assign last_rd_s     = rd_issue_s && (beat_r == last_idx_s);
  assign wr_issue_s    = advance_s && pipe_v_r[WR_LAT-1];
  assign last_wr_s     = wr_issue_s && (pipe_idx_r[WR_LAT-1] == last_idx_s);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (!iq_empty_i) state_s = FETCH; else state_s = IDLE;
      FETCH:   state_s = LATCH;
      LATCH:   if (!op_ok_s || no_beats_s) state_s = DONE; else state_s = RUN;
      RUN:     if (last_rd_s) state_s = DRAIN; else state_s = RUN;
      DRAIN:   if (last_wr_s) state_s = DONE; else state_s = DRAIN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    read_s   = (state_s == FETCH);
    busy_s   = (state_s != IDLE);
    done_s   = (state_s == DONE);
    op_err_s = (state_r == LATCH) && !op_ok_s;
    rd_en_s  = rd_issue_s;
    wr_en_s  = wr_issue_s;
    if (rd_issue_s) begin
      rd_addr_s = start_rd_r + beat_r[ADDR_W-1:0];
    end else begin
      rd_addr_s = ub_rd_addr_o;
    end
    if (wr_issue_s) begin
      wr_addr_s = start_wr_r + pipe_idx_r[WR_LAT-1][ADDR_W-1:0];
    end else begin
      wr_addr_s = ub_wr_addr_o;
    end
    if (state_r == LATCH) begin
      mac_op_s = instr_i.MAC_op;
      u_dim_s  = instr_i.U_dim;
    end else begin
      mac_op_s = mac_op_o;
      u_dim_s  = u_dim_o;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instruction_read_o <= 1'b0;
      ub_rd_en_o         <= 1'b0;
      ub_rd_addr_o       <= {ADDR_W{1'b0}};
      ub_wr_en_o         <= 1'b0;
      ub_wr_addr_o       <= {ADDR_W{1'b0}};
      mac_op_o           <= 3'd0;
      u_dim_o            <= 8'd0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      op_err_o           <= 1'b0;
    end else begin
      instruction_read_o <= read_s;
      ub_rd_en_o         <= rd_en_s;
      ub_rd_addr_o       <= rd_addr_s;
      ub_wr_en_o         <= wr_en_s;
      ub_wr_addr_o       <= wr_addr_s;
      mac_op_o           <= mac_op_s;
      u_dim_o            <= u_dim_s;
      busy_o             <= busy_s;
      done_o             <= done_s;
      op_err_o           <= op_err_s;
    end
  end

  // Working registers, beat counter and the read-to-write delay line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      beat_r     <= 16'd0;
      n_beats_r  <= 16'd0;
      start_rd_r <= {ADDR_W{1'b0}};
      start_wr_r <= {ADDR_W{1'b0}};
      pipe_v_r   <= {WR_LAT{1'b0}};
      for (int k = 0; k < WR_LAT; k++) begin
        pipe_idx_r[k] <= 16'd0;
      end
    end else if (state_r == LATCH) begin
      beat_r     <= 16'd0;
      n_beats_r  <= n_prod_s;
      start_rd_r <= instr_i.unified_buffer_addr_start_rd[ADDR_W-1:0];
      start_wr_r <= instr_i.unified_buffer_addr_start_wr[ADDR_W-1:0];
      pipe_v_r   <= {WR_LAT{1'b0}};
    end else if (advance_s) begin
      if (rd_issue_s) begin
        beat_r <= beat_r + 16'd1;
      end
      pipe_v_r[0]   <= rd_issue_s;
      pipe_idx_r[0] <= beat_r;
      for (int k = 1; k < WR_LAT; k++) begin
        pipe_v_r[k]   <= pipe_v_r[k-1];
        pipe_idx_r[k] <= pipe_idx_r[k-1];
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Saturating count of busy cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_cycles_o <= 32'd0;
    end else if (busy_o && (perf_cycles_o != 32'hFFFF_FFFF)) begin
      perf_cycles_o <= perf_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: expected beat addresses are queued with each
// instruction and popped as the DUT issues beats; timing is checked against recorded stall history.
module tb_instruction_sequencer;
  import tpu_package::*;

  localparam int ADDR_W = 12;
  localparam int WR_LAT = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              iq_empty_i = 1'b1;
  decode_registers_t instr_i = '0;
  logic              stall_i = 1'b0;
  logic              instruction_read_o, ub_rd_en_o, ub_wr_en_o, busy_o, done_o, op_err_o;
  logic [ADDR_W-1:0] ub_rd_addr_o, ub_wr_addr_o;
  logic [2:0]        mac_op_o;
  logic [7:0]        u_dim_o;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]       perf_cycles_o;
`endif

  instruction_sequencer #(.ADDR_W(ADDR_W), .WR_LAT(WR_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .iq_empty_i(iq_empty_i), .instr_i(instr_i), .stall_i(stall_i),
    .instruction_read_o(instruction_read_o),
    .ub_rd_en_o(ub_rd_en_o), .ub_rd_addr_o(ub_rd_addr_o),
    .ub_wr_en_o(ub_wr_en_o), .ub_wr_addr_o(ub_wr_addr_o),
    .mac_op_o(mac_op_o), .u_dim_o(u_dim_o),
    .busy_o(busy_o), .done_o(done_o), .op_err_o(op_err_o)
`ifdef SEQ_PERF_CNT_EN
    , .perf_cycles_o(perf_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  decode_registers_t iq[$];
  logic [ADDR_W-1:0] exp_rd[$], exp_wr[$];
  int rd_cyc[$], wr_cyc[$], done_cyc[$], err_cyc[$], pop_cyc[$];
  bit stall_hist [int];

  // Monitor: pops the scoreboard on every beat and records event cycles.
  initial forever begin : monitor
    logic [ADDR_W-1:0] e;
    @(negedge clk_i);
    cyc++;
    stall_hist[cyc] = stall_i;
    if (rst_i) begin
      if (ub_rd_en_o) begin
        vec_cnt++;
        if (exp_rd.size() == 0) begin
          err_cnt++;
          $display("FAIL rd_unexpected: got read at %h, required no read", ub_rd_addr_o);
        end else begin
          e = exp_rd.pop_front();
          if (ub_rd_addr_o !== e) begin
            err_cnt++;
            $display("FAIL rd_addr: got %h, required %h", ub_rd_addr_o, e);
          end
        end
        rd_cyc.push_back(cyc);
      end
      if (ub_wr_en_o) begin
        vec_cnt++;
        if (exp_wr.size() == 0) begin
          err_cnt++;
          $display("FAIL wr_unexpected: got write at %h, required no write", ub_wr_addr_o);
        end else begin
          e = exp_wr.pop_front();
          if (ub_wr_addr_o !== e) begin
            err_cnt++;
            $display("FAIL wr_addr: got %h, required %h", ub_wr_addr_o, e);
          end
        end
        wr_cyc.push_back(cyc);
      end
      if (done_o) done_cyc.push_back(cyc);
      if (op_err_o) err_cyc.push_back(cyc);
      if (instruction_read_o) pop_cyc.push_back(cyc);
    end
  end

  // Instruction queue model: entry appears on instr_i the cycle after the pop.
  initial forever begin : queue_model
    logic pop_pend;
    @(negedge clk_i);
    pop_pend = instruction_read_o && rst_i;
    @(posedge clk_i);
    #1;
    if (pop_pend) begin
      vec_cnt++;
      if (iq.size() == 0) begin
        err_cnt++;
        $display("FAIL pop_while_empty: got pop, required none");
      end else begin
        instr_i = iq.pop_front();
      end
    end
    iq_empty_i = (iq.size() == 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int unstalled(int a, int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (stall_hist.exists(c) && !stall_hist[c]) n++;
    return n;
  endfunction

  task automatic push_instr(input logic [2:0] op, input logic [7:0] u, input logic [7:0] v,
                            input logic [7:0] it, input logic [15:0] rd, input logic [15:0] wr);
    decode_registers_t d;
    d.MAC_op = op; d.U_dim = u; d.V_dim = v; d.ITER_dim = it;
    d.unified_buffer_addr_start_rd = rd;
    d.unified_buffer_addr_start_wr = wr;
    iq.push_back(d);
    if (op == 3'b010) begin
      for (int i = 0; i < int'(v) * int'(it); i++) begin
        exp_rd.push_back(rd[ADDR_W-1:0] + ADDR_W'(i));
        exp_wr.push_back(wr[ADDR_W-1:0] + ADDR_W'(i));
      end
    end
  endtask

  task automatic clear_stats();
    rd_cyc.delete(); wr_cyc.delete(); done_cyc.delete(); err_cyc.delete(); pop_cyc.delete();
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cyc.size() < target && k < budget) begin
      @(negedge clk_i); #1; k++;
    end
    vec_cnt++;
    if (done_cyc.size() < target) begin
      err_cnt++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", done_cyc.size(), target);
    end
    repeat (4) @(negedge clk_i);
    #1;
  endtask

  task automatic wait_reads(input int target, input int budget);
    int k = 0;
    while (rd_cyc.size() < target && k < budget) begin
      @(negedge clk_i); #1; k++;
    end
    vec_cnt++;
    if (rd_cyc.size() < target) begin
      err_cnt++;
      $display("FAIL read_timeout: got %0d reads, required %0d", rd_cyc.size(), target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    vec_cnt++;
    if ({instruction_read_o, ub_rd_en_o, ub_rd_addr_o, ub_wr_en_o, ub_wr_addr_o, mac_op_o,
         u_dim_o, busy_o, done_o, op_err_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got rd_en=%b wr_en=%b busy=%b mac_op=%h, required all zero",
               ub_rd_en_o, ub_wr_en_o, busy_o, mac_op_o);
    end
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
  endtask

  task automatic test_basic();
    clear_stats();
    push_instr(3'b010, 8'h05, 8'd2, 8'd3, 16'h010, 16'h200);
    wait_done(1, 200);
    vec_cnt++;
    if (rd_cyc.size() != 6 || wr_cyc.size() != 6 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      err_cnt++;
      $display("FAIL basic_counts: got rd=%0d wr=%0d, required 6 and 6", rd_cyc.size(), wr_cyc.size());
    end
    for (int i = 0; i < rd_cyc.size() && i < wr_cyc.size(); i++) begin
      vec_cnt++;
      if (wr_cyc[i] - rd_cyc[i] != WR_LAT) begin
        err_cnt++;
        $display("FAIL basic_wr_lat: beat %0d got %0d cycles, required %0d", i, wr_cyc[i] - rd_cyc[i], WR_LAT);
      end
      if (i > 0) begin
        vec_cnt++;
        if (rd_cyc[i] - rd_cyc[i-1] != 1) begin
          err_cnt++;
          $display("FAIL basic_rd_gap: beat %0d got gap %0d, required 1", i, rd_cyc[i] - rd_cyc[i-1]);
        end
      end
    end
    vec_cnt++;
    if (done_cyc.size() != 1 || err_cyc.size() != 0 || pop_cyc.size() != 1) begin
      err_cnt++;
      $display("FAIL basic_pulses: got done=%0d op_err=%0d pops=%0d, required 1 0 1",
               done_cyc.size(), err_cyc.size(), pop_cyc.size());
    end
    vec_cnt++;
    if (done_cyc.size() > 0 && wr_cyc.size() == 6 && done_cyc[0] < wr_cyc[5]) begin
      err_cnt++;
      $display("FAIL basic_done_order: got done at %0d, required at or after %0d", done_cyc[0], wr_cyc[5]);
    end
    vec_cnt++;
    if (mac_op_o !== 3'b010 || u_dim_o !== 8'h05 || busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_latched: got mac_op=%h u_dim=%h busy=%b, required 2 05 0", mac_op_o, u_dim_o, busy_o);
    end
  endtask

  task automatic test_stall();
    clear_stats();
    push_instr(3'b010, 8'h05, 8'd2, 8'd3, 16'h010, 16'h200);
    wait_reads(3, 100);
    @(posedge clk_i); #1 stall_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 stall_i = 1'b0;
    wait_done(1, 200);
    vec_cnt++;
    if (rd_cyc.size() != 6 || wr_cyc.size() != 6) begin
      err_cnt++;
      $display("FAIL stall_counts: got rd=%0d wr=%0d, required 6 and 6", rd_cyc.size(), wr_cyc.size());
    end else begin
      vec_cnt++;
      if (rd_cyc[5] - rd_cyc[0] != 8 || wr_cyc[5] - rd_cyc[0] != 12) begin
        err_cnt++;
        $display("FAIL stall_span: got rd span %0d wr span %0d, required 8 and 12",
                 rd_cyc[5] - rd_cyc[0], wr_cyc[5] - rd_cyc[0]);
      end
      for (int i = 0; i < 6; i++) begin
        vec_cnt++;
        if (unstalled(rd_cyc[i], wr_cyc[i] - 1) != WR_LAT) begin
          err_cnt++;
          $display("FAIL stall_wr_lat: beat %0d got %0d unstalled cycles, required %0d",
                   i, unstalled(rd_cyc[i], wr_cyc[i] - 1), WR_LAT);
        end
        if (i > 0) begin
          vec_cnt++;
          if (unstalled(rd_cyc[i-1], rd_cyc[i] - 1) != 1) begin
            err_cnt++;
            $display("FAIL stall_rd_gap: beat %0d got %0d unstalled cycles, required 1",
                     i, unstalled(rd_cyc[i-1], rd_cyc[i] - 1));
          end
        end
      end
    end
    vec_cnt++;
    if (done_cyc.size() != 1) begin
      err_cnt++;
      $display("FAIL stall_done: got %0d done pulses, required 1", done_cyc.size());
    end
  endtask

  task automatic test_wrap();
    clear_stats();
    push_instr(3'b010, 8'h01, 8'd4, 8'd1, 16'hFFE, 16'h100);
    wait_done(1, 200);
    vec_cnt++;
    if (rd_cyc.size() != 4 || wr_cyc.size() != 4 || exp_rd.size() != 0 || done_cyc.size() != 1) begin
      err_cnt++;
      $display("FAIL wrap_counts: got rd=%0d wr=%0d done=%0d, required 4 4 1",
               rd_cyc.size(), wr_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_no_beats();
    clear_stats();
    push_instr(3'b001, 8'h03, 8'd2, 8'd2, 16'h010, 16'h200);
    wait_done(1, 100);
    vec_cnt++;
    if (rd_cyc.size() != 0 || wr_cyc.size() != 0 || err_cyc.size() != 1 ||
        done_cyc.size() != 1 || pop_cyc.size() != 1) begin
      err_cnt++;
      $display("FAIL bad_op: got rd=%0d wr=%0d op_err=%0d done=%0d pops=%0d, required 0 0 1 1 1",
               rd_cyc.size(), wr_cyc.size(), err_cyc.size(), done_cyc.size(), pop_cyc.size());
    end
    vec_cnt++;
    if (mac_op_o !== 3'b001 || u_dim_o !== 8'h03) begin
      err_cnt++;
      $display("FAIL bad_op_latch: got mac_op=%h u_dim=%h, required 1 03", mac_op_o, u_dim_o);
    end
    clear_stats();
    push_instr(3'b010, 8'h03, 8'd0, 8'd5, 16'h010, 16'h200);
    wait_done(1, 100);
    vec_cnt++;
    if (rd_cyc.size() != 0 || wr_cyc.size() != 0 || err_cyc.size() != 0 || done_cyc.size() != 1) begin
      err_cnt++;
      $display("FAIL zero_v: got rd=%0d wr=%0d op_err=%0d done=%0d, required 0 0 0 1",
               rd_cyc.size(), wr_cyc.size(), err_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_reset_midrun();
    int n_rd, n_wr;
    clear_stats();
    push_instr(3'b010, 8'h07, 8'd2, 8'd3, 16'h050, 16'h400);
    wait_reads(4, 100);
    #1 rst_i = 1'b0;
    #1;
    vec_cnt++;
    if ({instruction_read_o, ub_rd_en_o, ub_rd_addr_o, ub_wr_en_o, ub_wr_addr_o, mac_op_o,
         u_dim_o, busy_o, done_o, op_err_o} !== '0) begin
      err_cnt++;
      $display("FAIL midrun_reset_outputs: got rd_en=%b wr_en=%b busy=%b mac_op=%h, required all zero",
               ub_rd_en_o, ub_wr_en_o, busy_o, mac_op_o);
    end
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b1;
    n_rd = rd_cyc.size();
    n_wr = wr_cyc.size();
    repeat (20) @(negedge clk_i);
    #1;
    vec_cnt++;
    if (rd_cyc.size() != n_rd || wr_cyc.size() != n_wr || done_cyc.size() != 0 || pop_cyc.size() != 1) begin
      err_cnt++;
      $display("FAIL midrun_abandon: got new rd=%0d new wr=%0d done=%0d pops=%0d, required 0 0 0 1",
               rd_cyc.size() - n_rd, wr_cyc.size() - n_wr, done_cyc.size(), pop_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    push_instr(3'b010, 8'h01, 8'd1, 8'd2, 16'h020, 16'h300);
    push_instr(3'b010, 8'h02, 8'd3, 8'd1, 16'h040, 16'h340);
    wait_done(2, 300);
    repeat (10) @(negedge clk_i);
    #1;
    vec_cnt++;
    if (pop_cyc.size() != 2 || done_cyc.size() != 2 || rd_cyc.size() != 5 || wr_cyc.size() != 5) begin
      err_cnt++;
      $display("FAIL b2b_counts: got pops=%0d done=%0d rd=%0d wr=%0d, required 2 2 5 5",
               pop_cyc.size(), done_cyc.size(), rd_cyc.size(), wr_cyc.size());
    end else begin
      vec_cnt++;
      if (pop_cyc[1] - done_cyc[0] != 2) begin
        err_cnt++;
        $display("FAIL b2b_turnaround: got second pop %0d cycles after done, required 2",
                 pop_cyc[1] - done_cyc[0]);
      end
    end
    vec_cnt++;
    if (busy_o !== 1'b0 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      err_cnt++;
      $display("FAIL b2b_idle: got busy=%b pending rd=%0d wr=%0d, required 0 0 0",
               busy_o, exp_rd.size(), exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_no_beats();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
